serial_compare_accumulator: RTL

SERIAL_COMPARE_ACCUMULATOR -- requirements
Module: serial_compare_accumulator

---
 rtl/serial_compare_accumulator_pkg.sv | 21 ++
 rtl/serial_compare_accumulator_flag_check.sv | 21 ++
 rtl/serial_compare_accumulator.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_compare_accumulator_pkg.sv
// Shared types and constants for the serial compare accumulator.
// Flag triples are packed as {lt_n, eq_n, gt_n}, all active-low.
package serial_compare_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_LT = 2'd1,
    DEC_GT = 2'd2
  } decision_t;

  localparam int unsigned FLAG_LT = 2;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_GT = 0;

endpackage

// File: rtl/serial_compare_accumulator_flag_check.sv
// Combinational legality check and decode of one active-low lt/eq/gt triple.
module flag_check
  import serial_compare_accumulator_pkg::*;
(
  input  logic [2:0] flags_n,
  output logic       legal,
  output decision_t  dec
);

  always_comb begin
    legal = (flags_n[FLAG_LT] + flags_n[FLAG_EQ] + flags_n[FLAG_GT]) == 2'd2;
    dec   = DEC_EQ;
    // An illegal triple decodes as equal so it never moves the decision.
    if (legal && !flags_n[FLAG_LT]) begin
      dec = DEC_LT;
    end else if (legal && !flags_n[FLAG_GT]) begin
      dec = DEC_GT;
    end
  end

endmodule

// File: rtl/serial_compare_accumulator.sv
// Accumulates MSB-first per-bit compare flags into a word-level lt/eq/gt
// result with sticky illegal-triple error and a valid/ready result handshake.
module serial_compare_accumulator
  import serial_compare_accumulator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_first,
  input  logic lt_n,
  input  logic eq_n,
  input  logic gt_n,
  output logic bit_ready,
  output logic res_valid,
  input  logic res_ready,
  output logic res_lt_n,
  output logic res_eq_n,
  output logic res_gt_n,
  output logic res_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_t          state, state_next;
  logic [CW-1:0]   count, cnt_next;
  decision_t       decision, dec_next;
  logic            err, err_next;
  logic            legal;
  decision_t       bit_dec;
  logic            do_load;

  flag_check u_flag_check (
    .flags_n ({lt_n, eq_n, gt_n}),
    .legal   (legal),
    .dec     (bit_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      decision <= DEC_EQ;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= cnt_next;
      decision <= dec_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = count;
    dec_next   = decision;
    err_next   = err;
    do_load    = 1'b0;
    bit_ready  = 1'b1;
    res_valid  = 1'b0;
    res_lt_n   = 1'b1;
    res_eq_n   = 1'b1;
    res_gt_n   = 1'b1;
    res_err    = 1'b0;

    case (state)
      IDLE: begin
        if (bit_valid && bit_first) begin
          do_load = 1'b1;
        end
      end
      ACCUM: begin
        if (bit_valid) begin
          if (bit_first) begin
            do_load = 1'b1;
          end else begin
            cnt_next = count + CW'(1);
            err_next = err | ~legal;
            if (decision == DEC_EQ) begin
              dec_next = bit_dec;
            end
            if (cnt_next == CNT_LAST) begin
              state_next = HOLD;
            end
          end
        end
      end
      HOLD: begin
        bit_ready = 1'b0;
        res_valid = 1'b1;
        res_err   = err;
        res_lt_n  = err | (decision != DEC_LT);
        res_eq_n  = err | (decision != DEC_EQ);
        res_gt_n  = err | (decision != DEC_GT);
        if (res_ready) begin
          state_next = IDLE;
          cnt_next   = '0;
          dec_next   = DEC_EQ;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A first bit restarts the word from either IDLE or ACCUM.
    if (do_load) begin
      cnt_next   = CW'(1);
      dec_next   = bit_dec;
      err_next   = ~legal;
      state_next = (WIDTH == 1) ? HOLD : ACCUM;
    end
  end

endmodule
